// File: rtl/block_counter_mod_if.sv
// Control and display bundle for block_counter_mod.
// The board side drives SW/Mode/Load; the counter drives the count outputs.
interface block_counter_mod_if #(
    parameter int WIDTH = 4
);
    logic             SW;
    logic             Mode;
    logic             Load;
    logic [WIDTH-1:0] Load_value;
    logic [WIDTH-1:0] Output;
    logic             Tick;
    logic             Terminal;

    modport master (
        output SW, Mode, Load, Load_value,
        input  Output, Tick, Terminal
    );

    modport slave (
        input  SW, Mode, Load, Load_value,
        output Output, Tick, Terminal
    );
endinterface

// File: rtl/block_counter_mod.sv
// Prescaled modulo-(MAX+1) up/down counter with load, tick and wrap pulses.
// Define COUNTER_SYNC_EN to add 2-flop synchronisers on SW, Mode and Load.
module block_counter_mod #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9,
    parameter int DIV   = 25000000,
    parameter int PW    = 25
) (
    input  logic              clk_50M,
    input  logic              Reset,
    block_counter_mod_if.slave bus
);
    localparam logic [PW-1:0]    LP_PEND = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX);

    logic [PW-1:0]    r_p;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tick;
    logic             r_term;

    logic             w_tick;
    logic             w_sw;
    logic             w_mode;
    logic             w_load;
    logic [WIDTH-1:0] w_lv;
    logic [WIDTH-1:0] w_lv_clamp;
    logic [WIDTH-1:0] w_step;
    logic             w_wrap;

`ifdef COUNTER_SYNC_EN
    logic [1:0]       r_sw_s;
    logic [1:0]       r_mode_s;
    logic [1:0]       r_load_s;
    logic [WIDTH-1:0] r_lv_s1;
    logic [WIDTH-1:0] r_lv_s2;

    // Load_value rides the same two stages so it lines up with Load.
    always_ff @(posedge clk_50M) begin
        if (Reset) begin
            r_sw_s   <= '0;
            r_mode_s <= '0;
            r_load_s <= '0;
            r_lv_s1  <= '0;
            r_lv_s2  <= '0;
        end else begin
            r_sw_s   <= {r_sw_s[0], bus.SW};
            r_mode_s <= {r_mode_s[0], bus.Mode};
            r_load_s <= {r_load_s[0], bus.Load};
            r_lv_s1  <= bus.Load_value;
            r_lv_s2  <= r_lv_s1;
        end
    end

    assign w_sw   = r_sw_s[1];
    assign w_mode = r_mode_s[1];
    assign w_load = r_load_s[1];
    assign w_lv   = r_lv_s2;
`else
    assign w_sw   = bus.SW;
    assign w_mode = bus.Mode;
    assign w_load = bus.Load;
    assign w_lv   = bus.Load_value;
`endif

    assign w_tick     = (r_p == LP_PEND);
    assign w_lv_clamp = (w_lv > LP_MAX) ? LP_MAX : w_lv;

    always_comb begin
        w_step = r_cnt;
        w_wrap = 1'b0;
        if (!w_mode) begin
            if (r_cnt == LP_MAX) begin
                w_step = '0;
                w_wrap = 1'b1;
            end else begin
                w_step = r_cnt + WIDTH'(1);
            end
        end else begin
            if (r_cnt == '0) begin
                w_step = LP_MAX;
                w_wrap = 1'b1;
            end else begin
                w_step = r_cnt - WIDTH'(1);
            end
        end
    end

    // Load beats a coincident tick; the step is dropped and Terminal stays low.
    always_ff @(posedge clk_50M) begin
        if (Reset) begin
            r_p    <= '0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_term <= 1'b0;
        end else begin
            r_p    <= w_tick ? '0 : r_p + PW'(1);
            r_tick <= w_tick;
            r_term <= 1'b0;
            if (w_load) begin
                r_cnt <= w_lv_clamp;
            end else if (w_tick && w_sw) begin
                r_cnt  <= w_step;
                r_term <= w_wrap;
            end
        end
    end

    assign bus.Output   = r_cnt;
    assign bus.Tick     = r_tick;
    assign bus.Terminal = r_term;
endmodule

// File: tb/tb_block_counter_mod.sv
// Scoreboard bench for block_counter_mod (WIDTH=4, MAX=9, DIV=4).
// A cycle model queues expectations; a negedge monitor checks them.
module tb_block_counter_mod;
    localparam int W  = 4;
    localparam int MX = 9;
    localparam int D  = 4;
    localparam int P  = 3;
`ifdef COUNTER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [W-1:0] o;
        logic         t;
        logic         term;
    } exp_t;

    logic clk_50M = 1'b0;
    logic Reset   = 1'b1;
    always #5 clk_50M = ~clk_50M;

    block_counter_mod_if #(.WIDTH(W)) bus ();

    block_counter_mod #(
        .WIDTH(W),
        .MAX  (MX),
        .DIV  (D),
        .PW   (P)
    ) dut (
        .clk_50M(clk_50M),
        .Reset  (Reset),
        .bus    (bus.slave)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    int   m_p   = 0;
    int   m_cnt = 0;
    bit   m_tick, m_term;
    bit   sw, md, ld, tk;
    int   lv;
    bit [1:0] ps_sw, ps_md, ps_ld;
    int   ps_lv[2];
    exp_t e_push;

    always @(posedge clk_50M) begin
        if (Reset) begin
            m_p = 0; m_cnt = 0; m_tick = 0; m_term = 0;
            ps_sw = 0; ps_md = 0; ps_ld = 0;
            ps_lv[0] = 0; ps_lv[1] = 0;
        end else begin
`ifdef COUNTER_SYNC_EN
            sw = ps_sw[1]; md = ps_md[1]; ld = ps_ld[1]; lv = ps_lv[1];
            ps_sw = {ps_sw[0], bus.SW};
            ps_md = {ps_md[0], bus.Mode};
            ps_ld = {ps_ld[0], bus.Load};
            ps_lv[1] = ps_lv[0];
            ps_lv[0] = int'(bus.Load_value);
`else
            sw = bus.SW; md = bus.Mode; ld = bus.Load;
            lv = int'(bus.Load_value);
`endif
            tk = (m_p == D - 1);
            m_p = tk ? 0 : m_p + 1;
            m_tick = tk;
            m_term = 0;
            if (ld) begin
                m_cnt = (lv > MX) ? MX : lv;
            end else if (tk && sw) begin
                if (!md) begin
                    m_term = (m_cnt == MX);
                    m_cnt = (m_cnt + 1) % (MX + 1);
                end else begin
                    m_term = (m_cnt == 0);
                    m_cnt = (m_cnt + MX) % (MX + 1);
                end
            end
        end
        e_push.o    = W'(m_cnt);
        e_push.t    = m_tick;
        e_push.term = m_term;
        q.push_back(e_push);
    end

    exp_t e_pop;
    always @(negedge clk_50M) begin
        cyc++;
        if (q.size() > 0) begin
            e_pop = q.pop_front();
            total++;
            if (bus.Output !== e_pop.o || bus.Tick !== e_pop.t ||
                bus.Terminal !== e_pop.term) begin
                bad++;
                $display("FAIL sb cyc=%0d got o=%0d t=%b tc=%b want o=%0d t=%b tc=%b",
                         cyc, bus.Output, bus.Tick, bus.Terminal,
                         e_pop.o, e_pop.t, e_pop.term);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic align(input int target);
        for (int i = 0; i < 2 * D && m_p != target; i++)
            @(negedge clk_50M);
        chk("align", m_p, target);
    endtask

    task automatic pulse_load(input logic [W-1:0] v);
        bus.Load_value = v;
        bus.Load = 1'b1;
        step(1);
        bus.Load = 1'b0;
        step(LAT - 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.SW = 1'b1;
        bus.Mode = 1'b0;
        bus.Load = 1'b0;
        bus.Load_value = '0;
        Reset = 1'b1;

        step(3);
        chk("rst_out", bus.Output, 0);
        chk("rst_tick", bus.Tick, 0);
        chk("rst_term", bus.Terminal, 0);
        Reset = 1'b0;

        step(3);
        chk("pre_tick", bus.Tick, 0);
        step(1);
        chk("first_tick", bus.Tick, 1);
        chk("first_step", bus.Output, 1);

        step(36);
        chk("up_wrap_out", bus.Output, 0);
        chk("up_wrap_term", bus.Terminal, 1);

        step(8);
        chk("at_two", bus.Output, 2);
        bus.Mode = 1'b1;
        step(12);
        chk("dn_wrap_out", bus.Output, 9);
        chk("dn_wrap_term", bus.Terminal, 1);

        bus.SW = 1'b0;
        step(12);
        chk("hold_out", bus.Output, 9);
        chk("hold_tick", bus.Tick, 1);
        bus.SW = 1'b1;
        step(4);
        chk("resume", bus.Output, 8);

        pulse_load(4'd13);
        chk("clamp_out", bus.Output, 9);
        chk("clamp_term", bus.Terminal, 0);

        align((D - LAT) % D);
        pulse_load(4'd5);
        chk("ld_tick_out", bus.Output, 5);
        chk("ld_tick_tick", bus.Tick, 1);
        chk("ld_tick_term", bus.Terminal, 0);
        step(4);
        chk("after_ld", bus.Output, 4);

        bus.SW = 1'b0;
        step(LAT);
        pulse_load(4'd7);
        chk("ld7", bus.Output, 7);
        align(2);
        Reset = 1'b1;
        bus.SW = 1'b1;
        step(1);
        chk("mid_rst_out", bus.Output, 0);
        chk("mid_rst_tick", bus.Tick, 0);
        Reset = 1'b0;
        step(3);
        chk("rel_pre_tick", bus.Tick, 0);
        step(1);
        chk("rel_tick", bus.Tick, 1);

        bus.Mode = 1'b0;
        step(20);
        bus.Mode = 1'b1;
        step(1);
        bus.Mode = 1'b0;
        step(15);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
